exc_ctrl: RTL and testbench

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_ctrl.sv | 129 ++++++++++++
 tb/tb_exc_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: synchronises the external IRQ, arbitrates it against
// decoder faults, saves the link address and cause, and sequences entry, return and double-fault.
module exc_ctrl #(
    parameter logic [63:0] VECTOR = 64'h0000_0000_0000_00D8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ExtIRQ,
    input  logic             Exc,
    input  logic             ERet,
    input  logic [3:0]       EStatus,
    input  logic [63:0]      PC,
    output logic             EProc,
    output logic             ERetSel,
    output logic             IRQAck,
    output logic [63:0]      ELR,
    output logic [3:0]       ESR,
    output logic             IntMask,
    output logic             DFault,
    output logic [CNT_W-1:0] ExcCount
);

    localparam logic [2:0] RUN     = 3'd0;
    localparam logic [2:0] ENTRY   = 3'd1;
    localparam logic [2:0] HANDLER = 3'd2;
    localparam logic [2:0] RETURN  = 3'd3;
    localparam logic [2:0] FAULT   = 3'd4;

    localparam logic [3:0] CAUSE_IRQ = 4'b0001;

    // The handler vector is consumed by the next-PC mux; it must stay word aligned.
    if (VECTOR[1:0] != 2'b00) begin : g_vector_check
        $error("exc_ctrl: VECTOR must be word aligned");
    end

    logic [2:0]       state_q, state_d;
    logic             sync1_q, sync2_q;
    logic [63:0]      elr_q, elr_d;
    logic [3:0]       esr_q, esr_d;
    logic             mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             eproc_q, eproc_d;
    logic             eretsel_q, eretsel_d;
    logic             ack_q, ack_d;
    logic             dfault_q, dfault_d;
    logic             sync_exc;
    logic             irq_req;

    // The decoder's own IRQ cause is not a fault; real IRQs only come through the synchroniser.
    assign sync_exc = Exc & (EStatus != CAUSE_IRQ);
    assign irq_req  = sync2_q & ~mask_q;

    always_comb begin
        state_d = state_q;
        elr_d   = elr_q;
        esr_d   = esr_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (sync_exc || irq_req) begin
                    state_d = ENTRY;
                    elr_d   = PC;
                    esr_d   = sync_exc ? EStatus : CAUSE_IRQ;
                    mask_d  = 1'b1;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            ENTRY:   state_d = HANDLER;
            HANDLER: begin
                if (ERet) begin
                    state_d = RETURN;
                end else if (sync_exc) begin
                    state_d = FAULT;
                end
            end
            RETURN: begin
                state_d = RUN;
                mask_d  = 1'b0;
            end
            FAULT:   state_d = FAULT;
            default: state_d = RUN;
        endcase
        // Moore outputs are decoded from the next state so they register alongside it.
        eproc_d   = (state_d == ENTRY);
        ack_d     = (state_d == ENTRY) && (esr_d == CAUSE_IRQ);
        eretsel_d = (state_d == RETURN);
        dfault_d  = (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= RUN;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            elr_q     <= '0;
            esr_q     <= '0;
            mask_q    <= 1'b0;
            cnt_q     <= '0;
            eproc_q   <= 1'b0;
            eretsel_q <= 1'b0;
            ack_q     <= 1'b0;
            dfault_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= ExtIRQ;
            sync2_q   <= sync1_q;
            elr_q     <= elr_d;
            esr_q     <= esr_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            eproc_q   <= eproc_d;
            eretsel_q <= eretsel_d;
            ack_q     <= ack_d;
            dfault_q  <= dfault_d;
        end
    end

    assign EProc    = eproc_q;
    assign ERetSel  = eretsel_q;
    assign IRQAck   = ack_q;
    assign ELR      = elr_q;
    assign ESR      = esr_q;
    assign IntMask  = mask_q;
    assign DFault   = dfault_q;
    assign ExcCount = cnt_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl; flags are packed as {EProc, ERetSel, IRQAck, IntMask, DFault}.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset, ExtIRQ, Exc, ERet;
    logic [3:0]  EStatus;
    logic [63:0] PC;
    logic        EProc, ERetSel, IRQAck, IntMask, DFault;
    logic [63:0] ELR;
    logic [3:0]  ESR;
    logic [15:0] ExcCount;

    logic        sat_reset, sat_exc, sat_eret;
    logic        sat_eproc, sat_eretsel, sat_ack, sat_mask, sat_dfault;
    logic [63:0] sat_elr;
    logic [3:0]  sat_esr;
    logic [1:0]  sat_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exc_ctrl u_dut (
        .clk(clk), .reset(reset), .ExtIRQ(ExtIRQ), .Exc(Exc), .ERet(ERet),
        .EStatus(EStatus), .PC(PC), .EProc(EProc), .ERetSel(ERetSel), .IRQAck(IRQAck),
        .ELR(ELR), .ESR(ESR), .IntMask(IntMask), .DFault(DFault), .ExcCount(ExcCount)
    );

    // Narrow counter instance so saturation is reachable in a few exceptions.
    exc_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(sat_reset), .ExtIRQ(1'b0), .Exc(sat_exc), .ERet(sat_eret),
        .EStatus(4'b0010), .PC(64'h0), .EProc(sat_eproc), .ERetSel(sat_eretsel),
        .IRQAck(sat_ack), .ELR(sat_elr), .ESR(sat_esr), .IntMask(sat_mask),
        .DFault(sat_dfault), .ExcCount(sat_cnt)
    );

    wire [4:0] flags = {EProc, ERetSel, IRQAck, IntMask, DFault};

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick(2);
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL reset_flags got=%b exp=00000", flags); end
        total++; if (ELR !== 64'h0) begin bad++; $display("FAIL reset_elr got=%h exp=0", ELR); end
        total++; if (ESR !== 4'h0) begin bad++; $display("FAIL reset_esr got=%h exp=0", ESR); end
        total++; if (ExcCount !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", ExcCount); end
        reset = 1'b1;
        tick(1);
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL reset_release got=%b exp=00000", flags); end
    endtask

    task automatic test_sync_exc;
        Exc = 1'b1; EStatus = 4'b0010; PC = 64'h40;
        tick(1);
        Exc = 1'b0; EStatus = 4'b0000;
        total++; if (flags !== 5'b10010) begin bad++; $display("FAIL sexc_flags got=%b exp=10010", flags); end
        total++; if (ELR !== 64'h40) begin bad++; $display("FAIL sexc_elr got=%h exp=40", ELR); end
        total++; if (ESR !== 4'b0010) begin bad++; $display("FAIL sexc_esr got=%b exp=0010", ESR); end
        total++; if (ExcCount !== 16'd1) begin bad++; $display("FAIL sexc_cnt got=%0d exp=1", ExcCount); end
        tick(1);
        total++; if (flags !== 5'b00010) begin bad++; $display("FAIL sexc_handler got=%b exp=00010", flags); end
    endtask

    task automatic test_eret;
        ERet = 1'b1; PC = 64'h44;
        tick(1);
        ERet = 1'b0;
        total++; if (flags !== 5'b01010) begin bad++; $display("FAIL eret_flags got=%b exp=01010", flags); end
        total++; if (ELR !== 64'h40) begin bad++; $display("FAIL eret_elr got=%h exp=40", ELR); end
        tick(1);
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL eret_run got=%b exp=00000", flags); end
        tick(1);
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL eret_idle got=%b exp=00000", flags); end
    endtask

    task automatic test_irq;
        ExtIRQ = 1'b1; PC = 64'h0;
        tick(1);
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL irq_lat1 got=%b exp=00000", flags); end
        tick(1);
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL irq_lat2 got=%b exp=00000", flags); end
        PC = 64'h100;
        tick(1);
        total++; if (flags !== 5'b10110) begin bad++; $display("FAIL irq_entry got=%b exp=10110", flags); end
        total++; if (ESR !== 4'b0001) begin bad++; $display("FAIL irq_esr got=%b exp=0001", ESR); end
        total++; if (ELR !== 64'h100) begin bad++; $display("FAIL irq_elr got=%h exp=100", ELR); end
        total++; if (ExcCount !== 16'd2) begin bad++; $display("FAIL irq_cnt got=%0d exp=2", ExcCount); end
        ExtIRQ = 1'b0;
        tick(1);
        total++; if (flags !== 5'b00010) begin bad++; $display("FAIL irq_ack_drop got=%b exp=00010", flags); end
        ERet = 1'b1;
        tick(1);
        ERet = 1'b0;
        total++; if (flags !== 5'b01010) begin bad++; $display("FAIL irq_return got=%b exp=01010", flags); end
        tick(2);
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL irq_no_retake got=%b exp=00000", flags); end
    endtask

    task automatic test_ignored;
        Exc = 1'b1; EStatus = 4'b0001; ERet = 1'b1;
        tick(3);
        Exc = 1'b0; EStatus = 4'b0000; ERet = 1'b0;
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL ignored_flags got=%b exp=00000", flags); end
        total++; if (ExcCount !== 16'd2) begin bad++; $display("FAIL ignored_cnt got=%0d exp=2", ExcCount); end
    endtask

    task automatic test_priority;
        ExtIRQ = 1'b1;
        tick(2);
        Exc = 1'b1; EStatus = 4'b0010; PC = 64'h200;
        tick(1);
        Exc = 1'b0; EStatus = 4'b0000;
        total++; if (flags !== 5'b10010) begin bad++; $display("FAIL prio_entry got=%b exp=10010", flags); end
        total++; if (ESR !== 4'b0010) begin bad++; $display("FAIL prio_esr got=%b exp=0010", ESR); end
        tick(1);
        ERet = 1'b1;
        tick(1);
        ERet = 1'b0; PC = 64'h300;
        tick(1);
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL prio_run got=%b exp=00000", flags); end
        tick(1);
        total++; if (flags !== 5'b10110) begin bad++; $display("FAIL prio_irq_entry got=%b exp=10110", flags); end
        total++; if (ESR !== 4'b0001) begin bad++; $display("FAIL prio_irq_esr got=%b exp=0001", ESR); end
        total++; if (ELR !== 64'h300) begin bad++; $display("FAIL prio_irq_elr got=%h exp=300", ELR); end
        total++; if (ExcCount !== 16'd4) begin bad++; $display("FAIL prio_cnt got=%0d exp=4", ExcCount); end
        ExtIRQ = 1'b0;
        tick(1);
        ERet = 1'b1;
        tick(1);
        ERet = 1'b0;
        tick(2);
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL prio_no_dup got=%b exp=00000", flags); end
    endtask

    task automatic test_eret_wins;
        Exc = 1'b1; EStatus = 4'b0010; PC = 64'h400;
        tick(1);
        Exc = 1'b0;
        tick(1);
        ERet = 1'b1; Exc = 1'b1;
        tick(1);
        ERet = 1'b0; Exc = 1'b0; EStatus = 4'b0000;
        total++; if (flags !== 5'b01010) begin bad++; $display("FAIL eretwin_flags got=%b exp=01010", flags); end
        tick(1);
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL eretwin_run got=%b exp=00000", flags); end
        total++; if (ExcCount !== 16'd5) begin bad++; $display("FAIL eretwin_cnt got=%0d exp=5", ExcCount); end
    endtask

    task automatic test_fault;
        Exc = 1'b1; EStatus = 4'b0010; PC = 64'h500;
        tick(1);
        Exc = 1'b0;
        tick(1);
        Exc = 1'b1; PC = 64'h600;
        tick(1);
        Exc = 1'b0;
        total++; if (flags !== 5'b00011) begin bad++; $display("FAIL fault_flags got=%b exp=00011", flags); end
        total++; if (ESR !== 4'b0010) begin bad++; $display("FAIL fault_esr got=%b exp=0010", ESR); end
        for (int i = 0; i < 12; i++) begin
            Exc = i[0]; ERet = i[1]; ExtIRQ = i[2]; PC = 64'(i);
            tick(1);
            total++; if (flags !== 5'b00011 || ELR !== 64'h500) begin
                bad++; $display("FAIL fault_hold[%0d] got=%b/%h exp=00011/500", i, flags, ELR);
            end
        end
        Exc = 1'b0; ERet = 1'b0; ExtIRQ = 1'b0; EStatus = 4'b0000;
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL fault_reset_flags got=%b exp=00000", flags); end
        total++; if (ELR !== 64'h0 || ESR !== 4'h0 || ExcCount !== 16'd0) begin
            bad++; $display("FAIL fault_reset_regs got=%h/%h/%0d exp=0/0/0", ELR, ESR, ExcCount);
        end
    endtask

    task automatic test_reset_mid_entry;
        Exc = 1'b1; EStatus = 4'b0010; PC = 64'h700;
        tick(1);
        Exc = 1'b0;
        total++; if (flags !== 5'b10010) begin bad++; $display("FAIL mid_entry got=%b exp=10010", flags); end
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        total++; if (flags !== 5'b00000 || ELR !== 64'h0 || ExcCount !== 16'd0) begin
            bad++; $display("FAIL mid_reset got=%b/%h/%0d exp=00000/0/0", flags, ELR, ExcCount);
        end
        tick(2);
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL mid_after got=%b exp=00000", flags); end
    endtask

    task automatic test_saturate;
        logic [1:0] exp_cnt;
        sat_reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
            sat_exc = 1'b1;
            tick(1);
            sat_exc = 1'b0;
            total++; if ({sat_eproc, sat_eretsel, sat_ack, sat_mask, sat_dfault} !== 5'b10010 || sat_cnt !== exp_cnt) begin
                bad++; $display("FAIL sat_entry[%0d] got=%b/%0d exp=10010/%0d", i,
                    {sat_eproc, sat_eretsel, sat_ack, sat_mask, sat_dfault}, sat_cnt, exp_cnt);
            end
            tick(1);
            sat_eret = 1'b1;
            tick(1);
            sat_eret = 1'b0;
            tick(1);
        end
        total++; if (sat_cnt !== 2'd3 || sat_esr !== 4'b0010 || sat_elr !== 64'h0) begin
            bad++; $display("FAIL sat_final got=%0d/%b/%h exp=3/0010/0", sat_cnt, sat_esr, sat_elr);
        end
    endtask

    initial begin
        reset = 1'b0; ExtIRQ = 1'b0; Exc = 1'b0; ERet = 1'b0; EStatus = 4'b0000; PC = 64'h0;
        sat_reset = 1'b0; sat_exc = 1'b0; sat_eret = 1'b0;
        test_reset();
        test_sync_exc();
        test_eret();
        test_irq();
        test_ignored();
        test_priority();
        test_eret_wins();
        test_fault();
        test_reset_mid_entry();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
